// File: rtl/sudoku_check.sv
// sudoku_check -- self-contained Sudoku solution generator and checker.
//
// An internal generator produces one 9x9 grid row per clock. Each row is
// decoded to one-hot digits and accumulated into nine column masks and nine
// box masks. A sticky error flag catches bad digits and incomplete rows.
// After nine ROW cycles, one JUDGE cycle classifies the grid as correct or
// wrong. The judge cycle also clears the masks and advances the digit rotation.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset (0 = in reset)
//   num_correct  grids judged valid, saturating at 1023
//   num_wrong    grids judged invalid, saturating at 1023
//   cycles       rising edges since reset release, saturating at all-ones
//
// Build option:
//   SUDOKU_CHECK_FAULT_EN -- when defined, every grid with grid_seq == 15 is
//   corrupted. Cell (0,0) copies the digit of cell (0,1), so that grid is judged
//   wrong. When undefined, every generated grid is a valid solution.
//
// Phase: row_idx 0..8 is the ROW phase and row_idx 9 is the JUDGE phase. The
// decoded phase is kept in the internal signal 'phase' so that probes can bind
// to it.

module sudoku_check (
    input  logic        clk,
    input  logic        rst,
    output logic [9:0]  num_correct,
    output logic [9:0]  num_wrong,
    output logic [31:0] cycles
);

    localparam logic [0:0] PH_ROW   = 1'b0;
    localparam logic [0:0] PH_JUDGE = 1'b1;

    logic [3:0] row_idx;
    logic [3:0] grid_k;
    logic [3:0] grid_seq;
    logic [8:0] col_mask [9];
    logic [8:0] box_mask [9];
    logic       err;
    logic [0:0] phase;

    assign phase = (row_idx == 4'd9) ? PH_JUDGE : PH_ROW;

    // ------------------------------------------------------------------
    // Generator: digit(r,c) = ((3r + r/3 + c + k) mod 9) + 1
    // ------------------------------------------------------------------
    logic [5:0]  r6;
    logic [5:0]  k6;
    logic [35:0] gen_digits;

    assign r6 = {2'b00, row_idx};
    assign k6 = {2'b00, grid_k};

    always_comb begin
        gen_digits = '0;
        for (int c = 0; c < 9; c++) begin
            gen_digits[c*4 +: 4] =
                4'(((r6 * 6'd3) + (r6 / 6'd3) + 6'(c) + k6) % 6'd9) + 4'd1;
        end
`ifdef SUDOKU_CHECK_FAULT_EN
        // Copying cell (0,1) into cell (0,0) duplicates a digit in row 0,
        // column 0 and box 0.
        if (grid_seq == 4'd15 && row_idx == 4'd0) begin
            gen_digits[3:0] = gen_digits[7:4];
        end
`endif
    end

    // The row is kept as a net so that an external probe can override a
    // whole row cleanly.
    wire [35:0] row_digits;
    assign row_digits = gen_digits;

    // ------------------------------------------------------------------
    // Row decode: one-hot per cell, row completeness, bad-digit detect
    // ------------------------------------------------------------------
    logic [8:0] onehot [9];
    logic [8:0] row_or;
    logic       row_bad;

    always_comb begin
        row_or  = '0;
        row_bad = 1'b0;
        for (int c = 0; c < 9; c++) begin
            onehot[c] = '0;
        end
        for (int c = 0; c < 9; c++) begin
            if (row_digits[c*4 +: 4] >= 4'd1 && row_digits[c*4 +: 4] <= 4'd9) begin
                onehot[c] = 9'd1 << (row_digits[c*4 +: 4] - 4'd1);
            end else begin
                row_bad = 1'b1;
            end
            row_or = row_or | onehot[c];
        end
        if (row_or != 9'h1FF) begin
            row_bad = 1'b1;
        end
    end

    // Three columns fold into each box of the current band. Combine them here
    // so that each box register gets a single update per cycle.
    logic [8:0] box_add [3];
    logic [3:0] band_base;

    always_comb begin
        for (int b = 0; b < 3; b++) begin
            box_add[b] = onehot[3*b] | onehot[3*b+1] | onehot[3*b+2];
        end
    end

    assign band_base = (row_idx / 4'd3) * 4'd3;

    // ------------------------------------------------------------------
    // Judge: the grid is valid only if no error occurred and all 18 masks
    // are full.
    // ------------------------------------------------------------------
    logic masks_full;

    always_comb begin
        masks_full = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (col_mask[i] != 9'h1FF || box_mask[i] != 9'h1FF) begin
                masks_full = 1'b0;
            end
        end
    end

    wire grid_ok = !err && masks_full;

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_idx     <= '0;
            grid_k      <= '0;
            grid_seq    <= '0;
            err         <= 1'b0;
            num_correct <= '0;
            num_wrong   <= '0;
            for (int i = 0; i < 9; i++) begin
                col_mask[i] <= '0;
                box_mask[i] <= '0;
            end
        end else if (phase == PH_ROW) begin
            for (int c = 0; c < 9; c++) begin
                col_mask[c] <= col_mask[c] | onehot[c];
            end
            for (int b = 0; b < 3; b++) begin
                box_mask[band_base + 4'(b)] <= box_mask[band_base + 4'(b)] | box_add[b];
            end
            if (row_bad) begin
                err <= 1'b1;
            end
            row_idx <= row_idx + 4'd1;
        end else begin
            if (grid_ok) begin
                if (num_correct != 10'h3FF) begin
                    num_correct <= num_correct + 10'd1;
                end
            end else begin
                if (num_wrong != 10'h3FF) begin
                    num_wrong <= num_wrong + 10'd1;
                end
            end
            for (int i = 0; i < 9; i++) begin
                col_mask[i] <= '0;
                box_mask[i] <= '0;
            end
            err      <= 1'b0;
            row_idx  <= '0;
            grid_k   <= (grid_k == 4'd8) ? 4'd0 : grid_k + 4'd1;
            grid_seq <= grid_seq + 4'd1;
        end
    end

    // The free-running edge counter. Its next value is a net so that a probe
    // can preload it.
    wire [31:0] cycles_nxt;
    assign cycles_nxt = (cycles == 32'hFFFF_FFFF) ? cycles : cycles + 32'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycles <= '0;
        end else begin
            cycles <= cycles_nxt;
        end
    end

endmodule

// File: tb/tb_sudoku_check.sv
// tb_sudoku_check -- directed and randomized bench for sudoku_check.
// The reference model builds each 9x9 grid as an array. It then checks every
// row, column and box by counting digits. The expected counters follow from
// the number of edges since reset release.

module tb_sudoku_check;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  num_correct;
    logic [9:0]  num_wrong;
    logic [31:0] cycles;

    always #5 clk = ~clk;

    sudoku_check dut (
        .clk         (clk),
        .rst         (rst),
        .num_correct (num_correct),
        .num_wrong   (num_wrong),
        .cycles      (cycles)
    );

    // ---------------- scoreboard / model state ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    int          m_edges  = 0;
    int          m_correct = 0;
    int          m_wrong   = 0;
    logic [31:0] m_cycles  = '0;
    bit          preload_pending = 1'b0;
    int          forced_grid = -1;
    int          forced_row  = 0;
    int          forced_vals [9];
    logic [31:0] exp_q [$];

    function automatic bit grid_valid(input int g);
        int grid [9][9];
        int cnt [10];
        int d;
        int r;
        int c;
        for (int rr = 0; rr < 9; rr++) begin
            for (int cc = 0; cc < 9; cc++) begin
                grid[rr][cc] = ((3*rr + rr/3 + cc) % 9 + g % 9) % 9 + 1;
            end
        end
`ifdef SUDOKU_CHECK_FAULT_EN
        if (g % 16 == 15) grid[0][0] = grid[0][1];
`endif
        if (g == forced_grid) begin
            for (int cc = 0; cc < 9; cc++) grid[forced_row][cc] = forced_vals[cc];
        end
        for (int u = 0; u < 27; u++) begin
            for (int v = 0; v < 10; v++) cnt[v] = 0;
            for (int i = 0; i < 9; i++) begin
                if (u < 9) begin
                    r = u; c = i;
                end else if (u < 18) begin
                    r = i; c = u - 9;
                end else begin
                    r = ((u - 18) / 3) * 3 + i / 3;
                    c = ((u - 18) % 3) * 3 + i % 3;
                end
                d = grid[r][c];
                if (d < 1 || d > 9) return 1'b0;
                cnt[d]++;
            end
            for (int v = 1; v < 10; v++) if (cnt[v] != 1) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_edge();
        m_edges++;
        if (preload_pending) begin
            m_cycles = 32'hFFFF_FFFE;
            preload_pending = 1'b0;
        end else if (m_cycles != 32'hFFFF_FFFF) begin
            m_cycles = m_cycles + 32'd1;
        end
        if (m_edges % 10 == 0) begin
            if (grid_valid(m_edges / 10 - 1)) begin
                if (m_correct < 1023) m_correct++;
            end else begin
                if (m_wrong < 1023) m_wrong++;
            end
        end
    endtask

    task automatic model_reset();
        m_edges   = 0;
        m_correct = 0;
        m_wrong   = 0;
        m_cycles  = '0;
        forced_grid = -1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
        end
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        exp_q.push_back(32'(m_correct));
        exp_q.push_back(32'(m_wrong));
        exp_q.push_back(m_cycles);
        check({tag, ".num_correct"}, 32'(num_correct), exp_q.pop_front());
        check({tag, ".num_wrong"},   32'(num_wrong),   exp_q.pop_front());
        check({tag, ".cycles"},      cycles,           exp_q.pop_front());
    endtask

    // Called at a negedge: asserts reset mid-period, checks the immediate
    // clear, holds reset for two edges and releases it at a negedge.
    task automatic async_reset(input string tag);
        rst = 1'b0;
        #1;
        model_reset();
        check({tag, ".rst_correct"}, 32'(num_correct), 32'd0);
        check({tag, ".rst_wrong"},   32'(num_wrong),   32'd0);
        check({tag, ".rst_cycles"},  cycles,           32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic [35:0] fv;

    initial begin
        // ---- power-on reset: hold two edges, then release ----
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("por.num_correct", 32'(num_correct), 32'd0);
        check("por.cycles", cycles, 32'd0);
        rst = 1'b1;

        step(9);
        check_all("edge9");
        check("edge9.direct_correct", 32'(num_correct), 32'd0);
        step(1);
        check_all("edge10");
        check("edge10.direct_correct", 32'(num_correct), 32'd1);

        // ---- async reset at edge 25 + half period: partial grid discarded ----
        step(15);
        async_reset("mid25");
        step(10);
        check_all("after_mid25");
        check("after_mid25.direct_correct", 32'(num_correct), 32'd1);

        // ---- randomized run lengths ----
        for (int i = 0; i < 6; i++) begin
            step($urandom_range(1, 40));
            check_all($sformatf("rand%0d", i));
        end

        // ---- random mid-grid reset ----
        step($urandom_range(1, 9));
        async_reset("rand_rst");
        step($urandom_range(10, 35));
        check_all("after_rand_rst");

        // ---- force a row containing digit 0 ----
        forced_row = $urandom_range(0, 8);
        while (m_edges % 10 != forced_row) step(1);
        forced_grid = m_edges / 10;
        forced_vals[0] = 0;
        for (int c = 1; c < 9; c++) forced_vals[c] = $urandom_range(1, 9);
        for (int c = 0; c < 9; c++) fv[c*4 +: 4] = 4'(forced_vals[c]);
        force dut.row_digits = fv;
        step(1);
        release dut.row_digits;
        step(10 - forced_row);
        check_all("forced_zero");
        step(10);
        check_all("after_forced");

        // ---- long free run to saturation ----
        @(negedge clk);
        async_reset("long");
        step(160);
        check_all("edge160");
        step(160);
        check_all("edge320");
        step(10229 - 320);
        check_all("edge10229");
        step(1);
        check_all("edge10230");
        step(10);
        check_all("edge10240");

        // ---- cycles counter saturation via preload ----
        force dut.cycles_nxt = 32'hFFFF_FFFE;
        preload_pending = 1'b1;
        step(1);
        release dut.cycles_nxt;
        check("preload.cycles", cycles, 32'hFFFF_FFFE);
        step(1);
        check("sat1.cycles", cycles, 32'hFFFF_FFFF);
        check_all("sat1");
        step(3);
        check_all("sat_hold");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
